speaker_match_ctrl: RTL and testbench

Parametrised speaker-identification controller. It sequences an external distance engine (the `disteu` cfg/ready/valid protocol) over `SPEAKER_NUM` stored VQ codebooks and tracks the best and second-best distance. It then issues a one-cycle identification result with an absolute-threshold and a best-vs-runner-up margin rejection. It sits between MFCC extraction / codebook RAM and the result UART/display path, and generalises the fixed 4-speaker recogniser.

---
 rtl/speaker_match_pkg.sv | 26 ++
 rtl/min2_tracker.sv | 45 ++++
 rtl/speaker_match_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_speaker_match_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speaker_match_pkg.sv
// rtl/speaker_match_pkg.sv - shared state encoding, reject code and default sizes for speaker matching
package speaker_match_pkg;

    localparam int SPEAKER_NUM_DEF = 4;
    localparam int FRAME_NUM_DEF   = 200;
    localparam int FRAME_W_DEF     = 9;
    localparam int CB_WORDS_DEF    = 320;
    localparam int ADDR_W_DEF      = 11;
    localparam int DIST_W_DEF      = 30;
    localparam int RES_W_DEF       = 3;

    // One-hot controller states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CFG   = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_JUDGE = 5'b01000,
        ST_OUT   = 5'b10000
    } state_e;

    // All-ones code of the given width marks a rejected utterance
    function automatic logic [31:0] reject_code(input int unsigned res_w);
        reject_code = (32'h1 << res_w) - 32'h1;
    endfunction

endpackage

// File: rtl/min2_tracker.sv
// rtl/min2_tracker.sv - running best / second-best minimum with index of the best
module min2_tracker #(
    parameter int DIST_W = 30,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DIST_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DIST_W-1:0] best_o,
    output logic [DIST_W-1:0] second_o,
    output logic [IDX_W-1:0]  best_idx_o
);

    logic [DIST_W-1:0] best_q, second_q;
    logic [IDX_W-1:0]  idx_q;

    // Strict compares so an equal later value never displaces an earlier best
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q   <= '1;
            second_q <= '1;
            idx_q    <= '0;
        end else if (clear_i) begin
            best_q   <= '1;
            second_q <= '1;
            idx_q    <= '0;
        end else if (valid_i) begin
            if (data_i < best_q) begin
                second_q <= best_q;
                best_q   <= data_i;
                idx_q    <= idx_i;
            end else if (data_i < second_q) begin
                second_q <= data_i;
            end
        end
    end

    assign best_o     = best_q;
    assign second_o   = second_q;
    assign best_idx_o = idx_q;

endmodule

// File: rtl/speaker_match_ctrl.sv
// rtl/speaker_match_ctrl.sv - sequences the distance engine over all codebooks and judges the speaker (option: SPK_MATCH_SCORES_EN)
module speaker_match_ctrl
    import speaker_match_pkg::*;
#(
    parameter int SPEAKER_NUM = SPEAKER_NUM_DEF,
    parameter int FRAME_NUM   = FRAME_NUM_DEF,
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int CB_WORDS    = CB_WORDS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DIST_W      = DIST_W_DEF,
    parameter int RES_W       = RES_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DIST_W-1:0]  threshold,
    input  logic [DIST_W-1:0]  margin,
    input  logic               eng_ready,
    output logic               eng_cfg_valid,
    output logic [FRAME_W-1:0] eng_cfg_data,
    output logic               eng_cfg_last,
    input  logic               eng_o_valid,
    input  logic [DIST_W-1:0]  eng_o_data,
    input  logic [ADDR_W-1:0]  eng_cb_addr,
    output logic [ADDR_W-1:0]  cb_addr,
    output logic               busy,
    output logic [RES_W-1:0]   result,
    output logic [DIST_W-1:0]  result_dist,
    output logic               result_valid
`ifdef SPK_MATCH_SCORES_EN
    ,
    input  logic [RES_W-1:0]   score_idx,
    output logic [DIST_W-1:0]  score_data
`endif
);

    localparam logic [RES_W-1:0]   REJECT     = RES_W'(reject_code(RES_W));
    localparam logic [RES_W-1:0]   LAST_SPK   = RES_W'(SPEAKER_NUM - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAME_NUM - 1);
    localparam logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(CB_WORDS);

    state_e              state_q, state_d;
    logic [DIST_W-1:0]   thr_q, thr_d, mar_q, mar_d;
    logic [RES_W-1:0]    spk_q, spk_d;
    logic [ADDR_W-1:0]   bias_q, bias_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [DIST_W-1:0]   rdist_q, rdist_d;

    logic                trk_clear, trk_valid;
    logic [DIST_W-1:0]   best, second;
    logic [RES_W-1:0]    best_idx;
    logic                reject;

    min2_tracker #(.DIST_W(DIST_W), .IDX_W(RES_W)) u_min2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (trk_clear),
        .valid_i    (trk_valid),
        .data_i     (eng_o_data),
        .idx_i      (spk_q),
        .best_o     (best),
        .second_o   (second),
        .best_idx_o (best_idx)
    );

    // second never falls below best, so the margin subtraction cannot wrap
    assign reject = (best >= thr_q) ||
                    ((SPEAKER_NUM > 1) && ((second - best) < mar_q));

    // Codebook address is the engine's local address shifted into this speaker's slice
    assign cb_addr = eng_cb_addr + bias_q;

    // Next-state and output decode; abort overrides everything and freezes the result
    always_comb begin
        state_d       = state_q;
        thr_d         = thr_q;
        mar_d         = mar_q;
        spk_d         = spk_q;
        bias_d        = bias_q;
        frame_d       = frame_q;
        result_d      = result_q;
        rdist_d       = rdist_q;
        trk_clear     = 1'b0;
        trk_valid     = 1'b0;
        eng_cfg_valid = 1'b0;
        eng_cfg_data  = '0;
        eng_cfg_last  = 1'b0;
        busy          = 1'b0;
        result_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    thr_d     = threshold;
                    mar_d     = margin;
                    spk_d     = '0;
                    bias_d    = '0;
                    frame_d   = '0;
                    trk_clear = 1'b1;
                    state_d   = ST_CFG;
                end
            end
            ST_CFG: begin
                busy          = 1'b1;
                eng_cfg_valid = (frame_q <= LAST_FRAME);
                eng_cfg_data  = frame_q;
                eng_cfg_last  = (frame_q == LAST_FRAME);
                if (eng_cfg_valid && eng_ready) begin
                    if (eng_cfg_last) state_d = ST_WAIT;
                    else              frame_d = frame_q + FRAME_W'(1);
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (eng_o_valid) begin
                    trk_valid = 1'b1;
                    if (spk_q == LAST_SPK) begin
                        state_d = ST_JUDGE;
                    end else begin
                        spk_d   = spk_q + RES_W'(1);
                        bias_d  = bias_q + STRIDE;
                        frame_d = '0;
                        state_d = ST_CFG;
                    end
                end
            end
            ST_JUDGE: begin
                busy     = 1'b1;
                result_d = reject ? REJECT : best_idx;
                rdist_d  = best;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            trk_valid = 1'b0;
            result_d  = result_q;
            rdist_d   = rdist_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            thr_q    <= '0;
            mar_q    <= '0;
            spk_q    <= '0;
            bias_q   <= '0;
            frame_q  <= '0;
            result_q <= '0;
            rdist_q  <= '0;
        end else begin
            state_q  <= state_d;
            thr_q    <= thr_d;
            mar_q    <= mar_d;
            spk_q    <= spk_d;
            bias_q   <= bias_d;
            frame_q  <= frame_d;
            result_q <= result_d;
            rdist_q  <= rdist_d;
        end
    end

    assign result      = result_q;
    assign result_dist = rdist_q;

`ifdef SPK_MATCH_SCORES_EN
    logic [DIST_W-1:0] score_q [SPEAKER_NUM];

    // Per-speaker distance capture, wiped at every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SPEAKER_NUM; i++) score_q[i] <= '0;
        end else if (trk_clear) begin
            for (int i = 0; i < SPEAKER_NUM; i++) score_q[i] <= '0;
        end else if (trk_valid) begin
            for (int i = 0; i < SPEAKER_NUM; i++)
                if (spk_q == RES_W'(i)) score_q[i] <= eng_o_data;
        end
    end

    // Combinational read; indices past the last speaker read as zero
    always_comb begin
        score_data = '0;
        for (int i = 0; i < SPEAKER_NUM; i++)
            if (score_idx == RES_W'(i)) score_data = score_q[i];
    end
`endif

endmodule

// File: tb/tb_speaker_match_ctrl.sv
// tb/tb_speaker_match_ctrl.sv - randomized self-checking bench for speaker_match_ctrl
module tb_speaker_match_ctrl;

    typedef logic [29:0] dist_t;
    typedef dist_t dist_arr_t [4];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    dist_t       threshold = '0;
    dist_t       margin = '0;
    logic        eng_ready = 1'b0;
    logic        eng_cfg_valid;
    logic [8:0]  eng_cfg_data;
    logic        eng_cfg_last;
    logic        eng_o_valid = 1'b0;
    dist_t       eng_o_data = '0;
    logic [10:0] eng_cb_addr = '0;
    logic [10:0] cb_addr;
    logic        busy;
    logic [2:0]  result;
    dist_t       result_dist;
    logic        result_valid;
`ifdef SPK_MATCH_SCORES_EN
    logic [2:0]  score_idx = '0;
    dist_t       score_data;
`endif

    int total = 0;
    int bad = 0;

    speaker_match_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .threshold    (threshold),
        .margin       (margin),
        .eng_ready    (eng_ready),
        .eng_cfg_valid(eng_cfg_valid),
        .eng_cfg_data (eng_cfg_data),
        .eng_cfg_last (eng_cfg_last),
        .eng_o_valid  (eng_o_valid),
        .eng_o_data   (eng_o_data),
        .eng_cb_addr  (eng_cb_addr),
        .cb_addr      (cb_addr),
        .busy         (busy),
        .result       (result),
        .result_dist  (result_dist),
        .result_valid (result_valid)
`ifdef SPK_MATCH_SCORES_EN
        ,
        .score_idx    (score_idx),
        .score_data   (score_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference: sort-free min search over the whole utterance, then the two rejection rules
    function automatic void ref_model(input dist_arr_t d, input dist_t thr, input dist_t mar,
                                      output logic [2:0] r, output dist_t rd);
        int bi = 0;
        longint sec = 64'h3FFF_FFFF;
        for (int i = 1; i < 4; i++) if (d[i] < d[bi]) bi = i;
        for (int i = 0; i < 4; i++) if (i != bi && longint'(d[i]) < sec) sec = longint'(d[i]);
        rd = d[bi];
        if (d[bi] >= thr || (sec - longint'(d[bi])) < longint'(mar)) r = 3'd7;
        else r = 3'(bi);
    endfunction

    // Plays the engine for one utterance; abort_spk >= 0 aborts 50 beats into that speaker
    task automatic run_ident(input dist_arr_t d, input dist_t thr, input dist_t mar,
                             input int abort_spk, output logic [2:0] res, output dist_t rdist);
        int beats, cyc, gap;
        @(negedge clk);
        start = 1'b1; threshold = thr; margin = mar;
        @(negedge clk);
        start = 1'b0; threshold = 30'($urandom); margin = 30'($urandom);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0d want 1", busy); end
        for (int s = 0; s < 4; s++) begin
            beats = 0; cyc = 0;
            while (beats < 200) begin
                if (cyc > 4000) begin
                    total++; bad++;
                    $display("FAIL cfg_timeout: got %0d beats want 200", beats);
                    break;
                end
                if (s == abort_spk && beats == 50) begin
                    abort = 1'b1; eng_ready = 1'b0; eng_o_valid = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    total++;
                    if (busy !== 1'b0 || eng_cfg_valid !== 1'b0 || result_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL abort_idle: got busy=%0d valid=%0d rv=%0d want 0 0 0",
                                 busy, eng_cfg_valid, result_valid);
                    end
                    repeat (3) begin
                        @(negedge clk);
                        total++;
                        if (result_valid !== 1'b0 || eng_cfg_valid !== 1'b0) begin
                            bad++;
                            $display("FAIL abort_quiet: got rv=%0d valid=%0d want 0 0", result_valid, eng_cfg_valid);
                        end
                    end
                    res = result; rdist = result_dist;
                    return;
                end
                eng_ready   = 1'($urandom_range(0, 1));
                eng_o_valid = ($urandom_range(0, 7) == 0);
                eng_o_data  = 30'($urandom);
                eng_cb_addr = 11'($urandom_range(0, 319));
                #1;
                total++;
                if (cb_addr !== eng_cb_addr + 11'(s * 320)) begin
                    bad++;
                    $display("FAIL cb_addr spk%0d: got %0d want %0d", s, cb_addr, eng_cb_addr + 11'(s * 320));
                end
                total++;
                if (eng_cfg_valid !== 1'b1) begin
                    bad++; $display("FAIL cfg_valid spk%0d beat%0d: got %0d want 1", s, beats, eng_cfg_valid);
                end
                if (eng_ready) begin
                    total++;
                    if (eng_cfg_data !== 9'(beats) || eng_cfg_last !== (beats == 199)) begin
                        bad++;
                        $display("FAIL cfg_beat spk%0d: got data=%0d last=%0d want data=%0d last=%0d",
                                 s, eng_cfg_data, eng_cfg_last, beats, (beats == 199));
                    end
                    beats++;
                end
                @(negedge clk);
                cyc++;
            end
            eng_ready = 1'b0; eng_o_valid = 1'b0;
            total++;
            if (eng_cfg_valid !== 1'b0) begin
                bad++; $display("FAIL cfg_valid_wait spk%0d: got %0d want 0", s, eng_cfg_valid);
            end
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            start = 1'b0;
            eng_o_valid = 1'b1; eng_o_data = d[s];
            @(negedge clk);
            eng_o_valid = 1'b0;
        end
        total++;
        if (result_valid !== 1'b0) begin bad++; $display("FAIL rv_early: got %0d want 0", result_valid); end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL rv_latency: got %0d want 1", result_valid); end
        res = result; rdist = result_dist;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rv_width: got rv=%0d busy=%0d want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (eng_cfg_valid !== 1'b0 || eng_cfg_data !== 9'd0 || eng_cfg_last !== 1'b0) begin
            bad++; $display("FAIL reset_cfg: got %0d %0d %0d want 0 0 0", eng_cfg_valid, eng_cfg_data, eng_cfg_last);
        end
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 3'd0 || result_dist !== 30'd0) begin
            bad++; $display("FAIL reset_out: got busy=%0d rv=%0d r=%0d rd=%0d want 0", busy, result_valid, result, result_dist);
        end
        total++;
        if (cb_addr !== 11'd0) begin bad++; $display("FAIL reset_cb_addr: got %0d want 0", cb_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        dist_arr_t   tbl [5];
        dist_t       thr [5], mar [5], exp_d [5];
        logic [2:0]  exp_r [5];
        logic [2:0]  r;
        dist_t       rd;
        tbl[0] = '{30'd500, 30'd300, 30'd700, 30'd900};       thr[0] = 30'd20200; mar[0] = 30'd0;   exp_r[0] = 3'd1; exp_d[0] = 30'd300;
        tbl[1] = '{30'd300, 30'd300, 30'd800, 30'd800};       thr[1] = 30'd20200; mar[1] = 30'd0;   exp_r[1] = 3'd0; exp_d[1] = 30'd300;
        tbl[2] = '{30'd20200, 30'd25000, 30'd30000, 30'd20500}; thr[2] = 30'd20200; mar[2] = 30'd0; exp_r[2] = 3'd7; exp_d[2] = 30'd20200;
        tbl[3] = '{30'd300, 30'd350, 30'd900, 30'd900};       thr[3] = 30'd20200; mar[3] = 30'd100; exp_r[3] = 3'd7; exp_d[3] = 30'd300;
        tbl[4] = '{30'd300, 30'd350, 30'd900, 30'd900};       thr[4] = 30'd20200; mar[4] = 30'd50;  exp_r[4] = 3'd0; exp_d[4] = 30'd300;
        for (int k = 0; k < 5; k++) begin
            run_ident(tbl[k], thr[k], mar[k], -1, r, rd);
            total++;
            if (r !== exp_r[k] || rd !== exp_d[k]) begin
                bad++; $display("FAIL directed%0d: got r=%0d d=%0d want r=%0d d=%0d", k, r, rd, exp_r[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_random();
        dist_arr_t  d;
        dist_t      thr, mar, ed, rd;
        logic [2:0] er, r;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) d[i] = 30'($urandom_range(0, 40) * 25);
            thr = 30'($urandom_range(200, 1100));
            mar = 30'($urandom_range(0, 3) * 25);
            ref_model(d, thr, mar, er, ed);
            run_ident(d, thr, mar, -1, r, rd);
            total++;
            if (r !== er || rd !== ed) begin
                bad++; $display("FAIL random%0d: got r=%0d d=%0d want r=%0d d=%0d", k, r, rd, er, ed);
            end
        end
    endtask

    task automatic test_abort();
        dist_arr_t  d;
        logic [2:0] r, prev_r;
        dist_t      rd, prev_d;
        d = '{30'd800, 30'd600, 30'd100, 30'd900};
        run_ident(d, 30'd20200, 30'd0, -1, prev_r, prev_d);
        run_ident('{30'd5, 30'd5, 30'd5, 30'd5}, 30'd20200, 30'd0, 2, r, rd);
        total++;
        if (r !== 3'd2 || rd !== 30'd100) begin
            bad++; $display("FAIL abort_hold: got r=%0d d=%0d want r=2 d=100", r, rd);
        end
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || eng_cfg_valid !== 1'b0) begin
            bad++; $display("FAIL start_with_abort: got busy=%0d valid=%0d want 0 0", busy, eng_cfg_valid);
        end
        d = '{30'd400, 30'd900, 30'd900, 30'd150};
        run_ident(d, 30'd20200, 30'd10, -1, r, rd);
        total++;
        if (r !== 3'd3 || rd !== 30'd150) begin
            bad++; $display("FAIL abort_rerun: got r=%0d d=%0d want r=3 d=150", r, rd);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; threshold = 30'd20200; margin = 30'd0;
        @(negedge clk);
        start = 1'b0; eng_ready = 1'b1;
        repeat (200) @(negedge clk);
        eng_ready = 1'b0; eng_o_valid = 1'b1; eng_o_data = 30'd77;
        @(negedge clk);
        eng_o_valid = 1'b0; eng_ready = 1'b1;
        repeat (200) @(negedge clk);
        eng_ready = 1'b0; eng_cb_addr = 11'd5;
        #1;
        total++;
        if (busy !== 1'b1 || eng_cfg_valid !== 1'b0 || cb_addr !== 11'd325) begin
            bad++; $display("FAIL mid_wait: got busy=%0d valid=%0d cb=%0d want 1 0 325", busy, eng_cfg_valid, cb_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result !== 3'd0 || result_dist !== 30'd0 || result_valid !== 1'b0 ||
            eng_cfg_valid !== 1'b0 || cb_addr !== 11'd5) begin
            bad++;
            $display("FAIL reset_mid: got busy=%0d r=%0d rd=%0d rv=%0d valid=%0d cb=%0d want 0 0 0 0 0 5",
                     busy, result, result_dist, result_valid, eng_cfg_valid, cb_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
